// File: rtl/gru_hidden_state_unloader.sv
// Captures the GRU hidden-state vector on h_valid and streams it one element per beat.
// Optional shadow frame buffer: define GRU_UNLOAD_DOUBLE_BUF_EN.
module gru_hidden_state_unloader #(
  parameter int H          = 16,
  parameter int DATA_WIDTH = 15,
  parameter int IDX_W      = $clog2(H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] h_t [H],
  input  logic                  h_valid,
  output logic                  busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_last,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] buf_r [H];

  logic                  accept_s;
  logic                  last_accept_s;
  logic                  start_s;
  logic                  restart_s;
  logic                  promote_s;
  logic                  load_buf_s;
  logic                  load_shadow_s;
  logic                  overrun_set_s;
  logic                  stream_nxt_s;
  logic                  shadow_full_s;
  logic                  shadow_full_nxt_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [DATA_WIDTH-1:0] first_data_s;

`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
  logic [DATA_WIDTH-1:0] shadow_r [H];
  logic                  shadow_full_r;
`endif

  // Beat handshake decode and frame capture/drop decisions
  always_comb begin
    accept_s      = m_valid & m_ready;
    last_accept_s = accept_s & m_last;
    start_s       = (state_r == IDLE) & h_valid;
    idx_nxt_s     = m_idx + IDX_W'(1);
`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
    shadow_full_s = shadow_full_r;
    promote_s     = last_accept_s & shadow_full_r;
    // On the last accept a full shadow is promoted, so a coincident vector refills it.
    load_shadow_s = h_valid & (state_r == STREAM) &
                    (last_accept_s ? shadow_full_r : ~shadow_full_r);
    overrun_set_s = h_valid & (state_r == STREAM) & ~last_accept_s & shadow_full_r;
    first_data_s  = promote_s ? shadow_r[0] : h_t[0];
`else
    shadow_full_s = 1'b0;
    promote_s     = 1'b0;
    load_shadow_s = 1'b0;
    overrun_set_s = h_valid & (state_r == STREAM) & ~last_accept_s;
    first_data_s  = h_t[0];
`endif
    load_buf_s        = start_s | (last_accept_s & h_valid & ~shadow_full_s);
    restart_s         = last_accept_s & (h_valid | shadow_full_s);
    stream_nxt_s      = start_s | ((state_r == STREAM) & ~(last_accept_s & ~restart_s));
    shadow_full_nxt_s = load_shadow_s | (shadow_full_s & ~promote_s);
  end

  // Stream FSM with registered beat outputs, status flags and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      m_valid   <= 1'b0;
      m_data    <= {DATA_WIDTH{1'b0}};
      m_idx     <= {IDX_W{1'b0}};
      m_last    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      busy <= stream_nxt_s | shadow_full_nxt_s;
      if (overrun_set_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
      if (last_accept_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= STREAM;
            m_valid <= 1'b1;
            m_idx   <= {IDX_W{1'b0}};
            m_data  <= h_t[0];
            m_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (accept_s) begin
            if (m_last) begin
              if (restart_s) begin
                m_idx  <= {IDX_W{1'b0}};
                m_data <= first_data_s;
                m_last <= 1'b0;
              end else begin
                state_r <= IDLE;
                m_valid <= 1'b0;
                m_idx   <= {IDX_W{1'b0}};
                m_last  <= 1'b0;
              end
            end else begin
              m_idx  <= idx_nxt_s;
              m_data <= buf_r[idx_nxt_s];
              m_last <= (idx_nxt_s == IDX_W'(H - 1));
            end
          end
        end
        default: begin
          state_r <= IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

  // Active frame buffer: direct capture or promotion of the shadow frame
  always_ff @(posedge clk) begin
    if (load_buf_s) begin
      buf_r <= h_t;
`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
    end else if (promote_s) begin
      buf_r <= shadow_r;
`endif
    end
  end

`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
  // Shadow occupancy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_full_r <= 1'b0;
    end else begin
      shadow_full_r <= shadow_full_nxt_s;
    end
  end

  // Shadow frame storage
  always_ff @(posedge clk) begin
    if (load_shadow_s) begin
      shadow_r <= h_t;
    end
  end
`endif

endmodule

// File: tb/tb_gru_hidden_state_unloader.sv
// Directed bench for gru_hidden_state_unloader; expectations follow GRU_UNLOAD_DOUBLE_BUF_EN.
module tb_gru_hidden_state_unloader;
  localparam int H  = 16;
  localparam int DW = 15;
  localparam int IW = 4;
`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
  localparam int FC3 = 4;
`else
  localparam int FC3 = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] h_t [H];
  logic          h_valid;
  logic          busy;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic          m_last;
  logic          overrun;
  logic          clr_overrun;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;
  int pat [8] = '{1, 0, 0, 1, 1, 1, 0, 1};

  always #5 clk = ~clk;

  gru_hidden_state_unloader dut (
    .clk(clk), .rst(rst), .h_t(h_t), .h_valid(h_valid), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .overrun(overrun), .clr_overrun(clr_overrun), .frame_cnt(frame_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int mult, input int add);
    for (int i = 0; i < H; i++) h_t[i] = DW'(mult * i + add);
  endtask

  task automatic check_beat(input string tag, input int i, input int mult, input int add);
    logic [DW-1:0] e;
    e = DW'(mult * i + add);
    check($sformatf("%s_valid%0d", tag, i), m_valid, 1);
    check($sformatf("%s_idx%0d", tag, i), m_idx, i);
    check($sformatf("%s_data%0d", tag, i), m_data, e);
    check($sformatf("%s_last%0d", tag, i), m_last, (i == H - 1) ? 1 : 0);
  endtask

  // Expects beat 0 visible now; accepts every beat with m_ready=1.
  task automatic drain_frame(input string tag, input int mult, input int add);
    for (int i = 0; i < H; i++) begin
      check_beat(tag, i, mult, add);
      m_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_idx;
    rst = 1'b1; h_valid = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
    set_vec(0, 0);
    tick(); tick();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_idx", m_idx, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fcnt", frame_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: full-throughput frame, data 1..16
    set_vec(1, 1); h_valid = 1'b1; m_ready = 1'b1;
    tick();
    h_valid = 1'b0;
    check("t1_busy", busy, 1);
    drain_frame("t1", 1, 1);
    check("t1_end_valid", m_valid, 0);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_busy_after", busy, 0);

    // 2: backpressure pattern; input vector scrambled after capture
    set_vec(1, 100); h_valid = 1'b1; m_ready = 1'b0;
    tick();
    h_valid = 1'b0;
    set_vec(0, 7);
    exp_idx = 0;
    for (int cyc = 0; cyc < 200 && exp_idx < H; cyc++) begin
      check_beat("t2", exp_idx, 1, 100);
      m_ready = pat[cyc % 8] != 0;
      if (m_ready) exp_idx++;
      tick();
    end
    check("t2_end_valid", m_valid, 0);
    check("t2_fcnt", frame_cnt, 2);

    // 3/4: frame B at beat 5, frame C (with clr_overrun, set wins) at beat 8
    set_vec(1, 1); h_valid = 1'b1; m_ready = 1'b1;
    tick();
    h_valid = 1'b0;
    for (int i = 0; i < H; i++) begin
      check_beat("t3a", i, 1, 1);
      if (i == 6) begin
`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
        check("t3_ovr_after_b", overrun, 0);
`else
        check("t3_ovr_after_b", overrun, 1);
`endif
      end
      if (i == 9) check("t3_ovr_after_c", overrun, 1);
      if (i == 5) begin
        set_vec(-1, 0); h_valid = 1'b1; clr_overrun = 1'b0;
      end else if (i == 8) begin
        set_vec(0, 500); h_valid = 1'b1; clr_overrun = 1'b1;
      end else begin
        h_valid = 1'b0; clr_overrun = 1'b0;
      end
      tick();
    end
`ifdef GRU_UNLOAD_DOUBLE_BUF_EN
    drain_frame("t4b", -1, 0);
`endif
    check("t3_end_valid", m_valid, 0);
    check("t3_end_ovr", overrun, 1);
    check("t3_fcnt", frame_cnt, FC3);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t3_ovr_clr", overrun, 0);

    // 5: h_valid coincident with last-beat accept
    set_vec(1, 1); h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    for (int i = 0; i < H; i++) begin
      check_beat("t5a", i, 1, 1);
      if (i == H - 1) begin
        set_vec(1, 50); h_valid = 1'b1;
      end
      tick();
    end
    h_valid = 1'b0;
    check("t5_ovr", overrun, 0);
    check("t5_fcnt_mid", frame_cnt, FC3 + 1);
    drain_frame("t5b", 1, 50);
    check("t5_end_valid", m_valid, 0);
    check("t5_fcnt", frame_cnt, FC3 + 2);

    // 6: reset mid-frame at beat 7, then a fresh frame
    set_vec(1, 1); h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_beat("t6a", i, 1, 1);
      tick();
    end
    check("t6_idx7", m_idx, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_fcnt", frame_cnt, 0);
    check("t6_rst_ovr", overrun, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_idx", m_idx, 0);
    tick();
    check("t6_idle_valid", m_valid, 0);
    set_vec(2, 0); h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    drain_frame("t6b", 2, 0);
    check("t6_fcnt", frame_cnt, 1);
    check("t6_end_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
